// File: rtl/tlc_phase_scheduler.sv
// Four-phase intersection scheduler: latches demand, grants green round-robin with
// min/max green, fixed yellow and all-red clearance, plus emergency preemption.
module tlc_phase_scheduler #(
  parameter int unsigned GREEN_MIN   = 5,
  parameter int unsigned GREEN_MAX   = 15,
  parameter int unsigned YEL_TIME    = 3,
  parameter int unsigned ALLRED_TIME = 1,
  parameter int unsigned TW          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] req,
  input  logic       emerg,
  input  logic [1:0] emerg_phase,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic       all_red,
  output logic [1:0] phase,
  output logic [3:0] pend
);

  typedef enum logic [1:0] {
    S_GREEN,
    S_YELLOW,
    S_ALL_RED
  } state_t;

  localparam logic [TW-1:0] G_MIN = TW'(GREEN_MIN);
  localparam logic [TW-1:0] G_MAX = TW'(GREEN_MAX);
  localparam logic [TW-1:0] Y_T   = TW'(YEL_TIME);
  localparam logic [TW-1:0] AR_T  = TW'(ALLRED_TIME);

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_inc;
  logic [1:0]    phase_nxt, rr_phase;
  logic [3:0]    pend_nxt;
  logic          other, rr_found;

  // All timed decisions compare against the value the timer takes on this edge,
  // so each interval lasts exactly its configured number of ticks.
  always_comb begin
    timer_inc = (tick && (timer != '1)) ? timer + 1'b1 : timer;
  end

  always_comb begin
    rr_phase = 2'd0;
    rr_found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!rr_found && pend[phase + 2'(k)]) begin
        rr_phase = phase + 2'(k);
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    other     = |(pend & ~(4'b0001 << phase));
    case (state)
      S_GREEN: begin
        if (emerg) begin
          if (emerg_phase != phase) state_nxt = S_YELLOW;
        end else if (other && (timer_inc >= G_MIN) &&
                     (!req[phase] || (timer_inc >= G_MAX))) begin
          state_nxt = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (timer_inc >= Y_T) state_nxt = S_ALL_RED;
      end
      S_ALL_RED: begin
        if (timer_inc >= AR_T) begin
          state_nxt = S_GREEN;
          if (emerg)         phase_nxt = emerg_phase;
          else if (rr_found) phase_nxt = rr_phase;
          else               phase_nxt = 2'd0;
        end
      end
      default: state_nxt = S_ALL_RED;
    endcase
    pend_nxt = pend | req;
    if ((state_nxt == S_GREEN) && (state != S_GREEN)) pend_nxt[phase_nxt] = 1'b0;
  end

  // Lamps are decoded from next state so they switch on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_ALL_RED;
      timer   <= '0;
      phase   <= 2'd0;
      pend    <= '0;
      green   <= '0;
      yellow  <= '0;
      all_red <= 1'b1;
    end else begin
      state   <= state_nxt;
      timer   <= (state_nxt != state) ? '0 : timer_inc;
      phase   <= phase_nxt;
      pend    <= pend_nxt;
      green   <= (state_nxt == S_GREEN)  ? (4'b0001 << phase_nxt) : '0;
      yellow  <= (state_nxt == S_YELLOW) ? (4'b0001 << phase_nxt) : '0;
      all_red <= (state_nxt == S_ALL_RED);
    end
  end

endmodule
